// File: rtl/bf_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : bf_seq_if
// | Purpose  : Fetch/execute-facing signal bundle of the loop sequencer.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
interface bf_seq_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
);
  logic               step_pc;
  logic [D_WIDTH-1:0] opcode;
  logic               opcode_valid;
  logic               exec_ready;
  logic               cell_zero;
  logic [A_WIDTH-1:0] pc;
  logic               ack_out;
  logic               exec_valid;
  logic               halted;
  logic               error;
  logic [15:0]        jump_count;

  // slave: the sequencer itself; master: fetch/execute environment
  modport slave (
    input  step_pc, opcode, opcode_valid, exec_ready, cell_zero,
    output pc, ack_out, exec_valid, halted, error, jump_count
  );

  modport master (
    output step_pc, opcode, opcode_valid, exec_ready, cell_zero,
    input  pc, ack_out, exec_valid, halted, error, jump_count
  );
endinterface
`default_nettype wire

// File: rtl/bf_loop_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : bf_loop_sequencer
// | Purpose  : Program counter, '['/']' loop control, squash and halt/error
// |            detection between fetch and execute.
// | Option   : BF_SEQ_JUMP_COUNT_EN enables the saturating jump_count counter.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
module bf_loop_sequencer #(
  parameter int A_WIDTH     = 12,
  parameter int D_WIDTH     = 8,
  parameter int STACK_DEPTH = 16,
  parameter int SCAN_WIDTH  = 8
) (
  input  wire     clk,
  input  wire     reset,
  bf_seq_if.slave bus
);
  localparam int c_sp_w  = $clog2(STACK_DEPTH) + 1;
  localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [D_WIDTH-1:0] c_op_halt  = '0;
  localparam logic [D_WIDTH-1:0] c_op_open  = D_WIDTH'(8'h5B);
  localparam logic [D_WIDTH-1:0] c_op_close = D_WIDTH'(8'h5D);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SCAN  = 2'd1,
    S_HALT  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [A_WIDTH-1:0]    pc_q, pc_d;
  logic [A_WIDTH-1:0]    op_addr_q, op_addr_d;
  logic [c_sp_w-1:0]     sp_q, sp_d;
  logic [SCAN_WIDTH-1:0] scan_q, scan_d;
  logic                  squash_q, squash_d;
  logic [A_WIDTH-1:0]    stack_q [STACK_DEPTH];

  logic                  active;
  logic                  consume;
  logic                  push;
  logic                  redirect;
  logic                  fwd;
  logic [c_idx_w-1:0]    top_idx;
  logic [A_WIDTH-1:0]    top_addr;

  assign active   = (state_q == S_RUN) || (state_q == S_SCAN);
  assign consume  = bus.opcode_valid && bus.exec_ready && active;
  assign top_idx  = c_idx_w'(sp_q - c_sp_w'(1));
  assign top_addr = stack_q[top_idx];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_addr_d = op_addr_q;
    sp_d      = sp_q;
    scan_d    = scan_q;
    squash_d  = squash_q;
    push      = 1'b0;
    redirect  = 1'b0;
    fwd       = 1'b0;

    if (active && bus.step_pc) begin
      op_addr_d = pc_q;
      pc_d      = pc_q + A_WIDTH'(1);
    end

    if (consume && squash_q) begin
      squash_d = 1'b0;
    end else if (consume) begin
      case (state_q)
        S_RUN: begin
          if (bus.opcode == c_op_halt) begin
            state_d = S_HALT;
          end else if (bus.opcode == c_op_open) begin
            if (bus.cell_zero) begin
              state_d = S_SCAN;
              scan_d  = SCAN_WIDTH'(1);
            end else if (sp_q == c_sp_w'(STACK_DEPTH)) begin
              state_d = S_ERROR;
            end else begin
              push = 1'b1;
              sp_d = sp_q + c_sp_w'(1);
            end
          end else if (bus.opcode == c_op_close) begin
            if (sp_q == '0) begin
              state_d = S_ERROR;
            end else if (bus.cell_zero) begin
              sp_d = sp_q - c_sp_w'(1);
            end else begin
              // The entry stays on the stack: the '[' is not re-executed,
              // the loop body restarts right after it.
              redirect = 1'b1;
              squash_d = 1'b1;
              pc_d     = top_addr + A_WIDTH'(1);
            end
          end else begin
            fwd = 1'b1;
          end
        end
        S_SCAN: begin
          if (bus.opcode == c_op_halt) begin
            state_d = S_ERROR;
          end else if (bus.opcode == c_op_open) begin
            if (scan_q == '1) state_d = S_ERROR;
            else              scan_d  = scan_q + SCAN_WIDTH'(1);
          end else if (bus.opcode == c_op_close) begin
            scan_d = scan_q - SCAN_WIDTH'(1);
            if (scan_q == SCAN_WIDTH'(1)) state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      pc_q      <= '0;
      op_addr_q <= '0;
      sp_q      <= '0;
      scan_q    <= '0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_addr_q <= op_addr_d;
      sp_q      <= sp_d;
      scan_q    <= scan_d;
      squash_q  <= squash_d;
    end
  end

  // Stack contents are don't-care after reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[c_idx_w-1:0]] <= op_addr_q;
  end

  assign bus.pc         = pc_q;
  assign bus.ack_out    = !reset && active && bus.exec_ready && !redirect;
  assign bus.exec_valid = !reset && fwd;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.error      = (state_q == S_ERROR);

`ifdef BF_SEQ_JUMP_COUNT_EN
  logic [15:0] jump_count_q, jump_count_d;

  always_comb begin
    jump_count_d = jump_count_q;
    if (redirect && (jump_count_q != 16'hFFFF)) jump_count_d = jump_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) jump_count_q <= '0;
    else       jump_count_q <= jump_count_d;
  end

  assign bus.jump_count = jump_count_q;
`else
  assign bus.jump_count = 16'd0;
`endif

endmodule
`default_nettype wire
